// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo up/down counter.
//   cnt_mode_e : wrap-around vs saturating arithmetic (sat_mode is cast to it)
//   cnt_dir_e  : count direction (up_down is cast to it)
//   ext_width  : width of the intermediate sum, one bit wider than the count
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  // One extra bit so count + step (or count + modulus) can never overflow.
  function automatic int ext_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/counter_step_calc.sv
// Combinational next-value calculator for one enabled counter update.
// Ports:
//   count_i  : current count (always within 0..MAX_VAL)
//   step_i   : increment/decrement amount
//   dir_i    : CNT_UP / CNT_DOWN
//   mode_i   : CNT_WRAP / CNT_SAT
//   next_o   : count after the update
//   wrap_o   : the update wrapped around the modulus
//   sat_o    : the update was clamped at 0 or MAX_VAL
module counter_step_calc
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = (2**WIDTH) - 1,
  parameter int STEP_W  = 2
) (
  input  logic [WIDTH-1:0]  count_i,
  input  logic [STEP_W-1:0] step_i,
  input  cnt_dir_e          dir_i,
  input  cnt_mode_e         mode_i,
  output logic [WIDTH-1:0]  next_o,
  output logic              wrap_o,
  output logic              sat_o
);

  localparam int EW = ext_width(WIDTH);
  localparam logic [EW-1:0] MAX_EXT = EW'(MAX_VAL);
  // MAX_VAL+1 is at most 2**WIDTH, which fits in EW bits.
  localparam logic [EW-1:0] MOD_EXT = EW'(MAX_VAL) + EW'(1);

  logic [EW-1:0] count_ext;
  logic [EW-1:0] step_ext;
  logic [EW-1:0] sum_ext;
  logic [EW-1:0] res_ext;

  assign count_ext = EW'(count_i);
  assign step_ext  = EW'(step_i);
  assign sum_ext   = count_ext + step_ext;

  always_comb begin
    res_ext = count_ext;
    wrap_o  = 1'b0;
    sat_o   = 1'b0;
    if (dir_i == CNT_UP) begin
      if (sum_ext <= MAX_EXT) begin
        res_ext = sum_ext;
      end else if (mode_i == CNT_WRAP) begin
        res_ext = sum_ext - MOD_EXT;
        wrap_o  = 1'b1;
      end else begin
        res_ext = MAX_EXT;
        sat_o   = 1'b1;
      end
    end else begin
      if (step_ext <= count_ext) begin
        res_ext = count_ext - step_ext;
      end else if (mode_i == CNT_WRAP) begin
        // count < step here, so count + modulus - step stays below the modulus.
        res_ext = count_ext + MOD_EXT - step_ext;
        wrap_o  = 1'b1;
      end else begin
        res_ext = '0;
        sat_o   = 1'b1;
      end
    end
  end

  // Result is always <= MAX_VAL, so the top bit is always zero.
  assign next_o = res_ext[WIDTH-1:0];

endmodule

// File: rtl/modulo_updown_counter.sv
// Parametrised modulo up/down counter with load, programmable step and
// runtime wrap/saturate selection.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load, d_in : synchronous load (value clamped to MAX_VAL), beats enable
//   enable     : advance by step this cycle
//   up_down    : 1 = up, 0 = down
//   sat_mode   : 0 = wrap modulo MAX_VAL+1, 1 = saturate at 0/MAX_VAL
//   step       : increment/decrement amount
//   count      : registered count
//   wrap, sat  : registered one-cycle event pulses for the last update
//   at_max     : count == MAX_VAL (combinational)
//   at_min     : count == 0 (combinational)
module modulo_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = (2**WIDTH) - 1,
  parameter int STEP_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              up_down,
  input  logic              enable,
  input  logic              sat_mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  d_in,
  output logic [WIDTH-1:0]  count,
  output logic              wrap,
  output logic              sat,
  output logic              at_max,
  output logic              at_min
);

  if (!((STEP_W <= WIDTH) && (MAX_VAL >= 0) && (MAX_VAL < 2**WIDTH) &&
        ((2**STEP_W) - 1 <= MAX_VAL + 1))) begin : g_bad_cfg
    $error("modulo_updown_counter: illegal WIDTH/MAX_VAL/STEP_W combination");
  end

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;

  logic [WIDTH-1:0] calc_next;
  logic             calc_wrap;
  logic             calc_sat;

  counter_step_calc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .STEP_W  (STEP_W)
  ) u_step_calc (
    .count_i (count_q),
    .step_i  (step),
    .dir_i   (cnt_dir_e'(up_down)),
    .mode_i  (cnt_mode_e'(sat_mode)),
    .next_o  (calc_next),
    .wrap_o  (calc_wrap),
    .sat_o   (calc_sat)
  );

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    if (load) begin
      // A clamped load is not a boundary event: no pulse.
      count_d = (d_in > MAX_W) ? MAX_W : d_in;
    end else if (enable) begin
      count_d = calc_next;
      wrap_d  = calc_wrap;
      sat_d   = calc_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign count  = count_q;
  assign wrap   = wrap_q;
  assign sat    = sat_q;
  assign at_max = (count_q == MAX_W);
  assign at_min = (count_q == '0);

endmodule
